// File: rtl/sifh_peak_reader.sv
// SiFH histogram read-out: scans every pixel's histogram on RAM port b, streams the peak bin per pixel.
// Optional clear-on-read of port a (requires a read-first RAM) is enabled with `define SIFH_CLEAR_ON_READ_EN.
module sifh_peak_reader #(
   parameter int PIX_W  = 4,
   parameter int BIN_W  = 6,
   parameter int NB     = PIX_W + BIN_W,
   parameter int PEAK_W = 8
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [NB-1:0]     raddr,
   output logic              rEnable,
   output logic              readFlag,
   input  logic [PEAK_W-1:0] counts,
   output logic [NB-1:0]     waddr,
   output logic              wEnable,
   output logic              writeFlag,
   output logic [PEAK_W-1:0] wdata,
   output logic              peak_valid,
   input  logic              peak_ready,
   output logic [PIX_W-1:0]  peak_pixel,
   output logic [BIN_W-1:0]  peak_bin,
   output logic [PEAK_W-1:0] peak_count,
   output logic [2:0]        dbg_state_o
);

   // Result handshake: a result transfers on a clock edge where peak_valid && peak_ready;
   // while peak_valid is high and peak_ready is low every peak_* field is held unchanged.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_FLUSH = 3'd2,
      S_EMIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [PIX_W-1:0] PIX_LAST = '1;
   localparam logic [BIN_W-1:0] BIN_LAST = '1;

   state_t              state_q, state_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [PEAK_W-1:0]   max_cnt_q, max_cnt_d;
   logic [BIN_W-1:0]    max_bin_q, max_bin_d;
   logic                rd_vld_q, rd_vld_d;
   logic [NB-1:0]       rd_addr_q, rd_addr_d;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SCAN;
         S_SCAN:  if (bin_q == BIN_LAST) state_d = S_FLUSH;
         S_FLUSH: state_d = S_EMIT;
         S_EMIT:  if (peak_ready) state_d = (pix_q == PIX_LAST) ? S_DONE : S_SCAN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      raddr      = '0;
      rEnable    = 1'b0;
      readFlag   = 1'b0;
      waddr      = '0;
      wEnable    = 1'b0;
      writeFlag  = 1'b0;
      wdata      = '0;
      peak_valid = 1'b0;
      peak_pixel = pix_q;
      peak_bin   = max_bin_q;
      peak_count = max_cnt_q;
      dbg_state_o = state_q;
      case (state_q)
         S_SCAN: begin
            raddr    = {pix_q, bin_q};
            rEnable  = 1'b1;
            readFlag = 1'b1;
         end
         S_EMIT:  peak_valid = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
`ifdef SIFH_CLEAR_ON_READ_EN
      // Zero each address in the same cycle its data is consumed.
      if (rd_vld_q) begin
         waddr     = rd_addr_q;
         wEnable   = 1'b1;
         writeFlag = 1'b1;
      end
`endif
   end

   always_comb begin
      pix_d     = pix_q;
      bin_d     = bin_q;
      max_cnt_d = max_cnt_q;
      max_bin_d = max_bin_q;
      rd_vld_d  = (state_q == S_SCAN);
      rd_addr_d = {pix_q, bin_q};
      // Strictly greater only, so ties keep the lowest bin.
      if (rd_vld_q && (counts > max_cnt_q)) begin
         max_cnt_d = counts;
         max_bin_d = rd_addr_q[BIN_W-1:0];
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pix_d     = '0;
               bin_d     = '0;
               max_cnt_d = '0;
               max_bin_d = '0;
            end
         end
         S_SCAN: bin_d = (bin_q == BIN_LAST) ? '0 : bin_q + 1'b1;
         S_EMIT: begin
            if (peak_ready && (pix_q != PIX_LAST)) begin
               pix_d     = pix_q + 1'b1;
               bin_d     = '0;
               max_cnt_d = '0;
               max_bin_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         pix_q     <= '0;
         bin_q     <= '0;
         max_cnt_q <= '0;
         max_bin_q <= '0;
         rd_vld_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         pix_q     <= pix_d;
         bin_q     <= bin_d;
         max_cnt_q <= max_cnt_d;
         max_bin_q <= max_bin_d;
         rd_vld_q  <= rd_vld_d;
         rd_addr_q <= rd_addr_d;
      end
   end

endmodule

// File: tb/tb_sifh_peak_reader.sv
// Directed bench for sifh_peak_reader with a read-first RAM model and an expected-result queue.
module tb_sifh_peak_reader;
  localparam int PIX_W  = 4;
  localparam int BIN_W  = 6;
  localparam int NB     = PIX_W + BIN_W;
  localparam int PEAK_W = 8;
  localparam int PIXELS = 16;
  localparam int BINS   = 64;
  localparam int RW     = PIX_W + BIN_W + PEAK_W;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic              start = 1'b0;
  logic              peak_ready = 1'b0;
  logic              busy, done, rEnable, readFlag, wEnable, writeFlag, peak_valid;
  logic [NB-1:0]     raddr, waddr;
  logic [PEAK_W-1:0] counts, wdata, peak_count;
  logic [PIX_W-1:0]  peak_pixel;
  logic [BIN_W-1:0]  peak_bin;
  logic [2:0]        dbg_state;

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sifh_peak_reader #(.PIX_W(PIX_W), .BIN_W(BIN_W), .NB(NB), .PEAK_W(PEAK_W)) dut (
    .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag), .counts(counts),
    .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag), .wdata(wdata),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pixel(peak_pixel),
    .peak_bin(peak_bin), .peak_count(peak_count), .dbg_state_o(dbg_state)
  );

  // read-first histogram RAM model with a bench-side load port
  logic [PEAK_W-1:0] mem [0:(1<<NB)-1];
  logic [PEAK_W-1:0] rd_q = '0;
  logic              tb_we = 1'b0;
  logic [NB-1:0]     tb_wa = '0;
  logic [PEAK_W-1:0] tb_wd = '0;
  assign counts = rd_q;
  always @(posedge clk) begin
    if (readFlag && rEnable) rd_q <= mem[raddr];
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (writeFlag && wEnable) mem[waddr] <= wdata;
  end

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int bad_wr = 0;
  int exp_bin[PIXELS];
  int exp_cnt[PIXELS];
  int t_start, t_done, t_valid;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen within budget", name);
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({busy, done, raddr, rEnable, readFlag, waddr, wEnable, writeFlag, wdata,
                peak_valid, peak_pixel, peak_bin, peak_count, dbg_state});
  endfunction

  // monitor: pops an expectation on every accepted result, and polices port a
  logic          prev_ren = 1'b0;
  logic [NB-1:0] prev_raddr = '0;
  always @(negedge clk) begin
    if (res && peak_valid && peak_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL result_unexpected: got %0h expected none", {peak_pixel, peak_bin, peak_count});
      end else begin
        check("result", 64'({peak_pixel, peak_bin, peak_count}), 64'(exp_q.pop_front()));
      end
    end
    if (!res) begin
      prev_ren   = 1'b0;
      prev_raddr = '0;
    end else begin
`ifdef SIFH_CLEAR_ON_READ_EN
      if (wEnable !== prev_ren || writeFlag !== prev_ren || wdata !== '0 ||
          (prev_ren && waddr !== prev_raddr)) bad_wr++;
`else
      if (wEnable !== 1'b0 || writeFlag !== 1'b0 || waddr !== '0 || wdata !== '0) bad_wr++;
`endif
      if (readFlag !== rEnable) bad_wr++;
      prev_ren   = rEnable;
      prev_raddr = raddr;
    end
  end

  // driver tasks (inputs change at posedge + 1)
  task automatic ram_clear();
    tb_we = 1'b1;
    tb_wd = '0;
    for (int i = 0; i < (1 << NB); i++) begin
      tb_wa = NB'(i);
      @(posedge clk); #1;
    end
    tb_we = 1'b0;
  endtask

  task automatic ram_wr(input int p, input int b, input int v);
    tb_we = 1'b1;
    tb_wa = {PIX_W'(p), BIN_W'(b)};
    tb_wd = PEAK_W'(v);
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic exp_clear();
    for (int p = 0; p < PIXELS; p++) begin
      exp_bin[p] = 0;
      exp_cnt[p] = 0;
    end
  endtask

  task automatic push_all();
    for (int p = 0; p < PIXELS; p++)
      exp_q.push_back({PIX_W'(p), BIN_W'(exp_bin[p]), PEAK_W'(exp_cnt[p])});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        t_done = cyc;
        break;
      end
    end
    if (!seen) fail_now(name);
    else begin
      @(negedge clk);
      check({name, "_pulse_end"}, 64'({done, busy}), 64'(2'b00));
    end
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int nz;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'(0));
    res = 1'b1;
    @(posedge clk); #1;
    ram_clear();

    // run 1: basic peaks, tie rule on pixel 2, ignored second start
    ram_wr(0, 5, 7);
    ram_wr(1, 63, 200);
    ram_wr(2, 3, 9);
    ram_wr(2, 40, 9);
    exp_clear();
    exp_bin[0] = 5;  exp_cnt[0] = 7;
    exp_bin[1] = 63; exp_cnt[1] = 200;
    exp_bin[2] = 3;  exp_cnt[2] = 9;
    push_all();
    peak_ready = 1'b1;
    pulse_start();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run1");
    check("start_to_done", 64'(t_done - t_start + 1), 64'(PIXELS * (BINS + 2) + 2));
    nz = 0;
    for (int a = 0; a < (1 << NB); a++) if (mem[a] != '0) nz++;
`ifdef SIFH_CLEAR_ON_READ_EN
    check("ram_cleared", 64'(nz), 64'(0));
`else
    check("ram_untouched", 64'(nz), 64'(4));
`endif

    // run 2: same RAM contents rescanned
`ifndef SIFH_CLEAR_ON_READ_EN
    exp_clear();
    exp_bin[0] = 5;  exp_cnt[0] = 7;
    exp_bin[1] = 63; exp_cnt[1] = 200;
    exp_bin[2] = 3;  exp_cnt[2] = 9;
`else
    exp_clear();
`endif
    push_all();
    pulse_start();
    wait_done("run2");

    // run 3: bin 0 / bin 63 / full-scale boundaries and another tie
    ram_clear();
    ram_wr(3, 0, 255);
    ram_wr(4, 10, 4);
    ram_wr(4, 11, 5);
    ram_wr(4, 12, 5);
    ram_wr(4, 30, 3);
    ram_wr(15, 62, 1);
    ram_wr(15, 63, 1);
    exp_clear();
    exp_bin[3] = 0;   exp_cnt[3] = 255;
    exp_bin[4] = 11;  exp_cnt[4] = 5;
    exp_bin[15] = 62; exp_cnt[15] = 1;
    push_all();
    pulse_start();
    wait_done("run3");

    // stall: hold peak_ready low on pixel 0
    ram_clear();
    ram_wr(0, 20, 33);
    exp_clear();
    exp_bin[0] = 20; exp_cnt[0] = 33;
    push_all();
    peak_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (peak_valid) begin
        seen = 1'b1;
        t_valid = cyc;
        break;
      end
    end
    if (!seen) fail_now("stall_valid");
    check("valid_latency", 64'(t_valid - (t_start + 1)), 64'(BINS + 1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({peak_valid, rEnable, readFlag, peak_pixel, peak_bin, peak_count}),
            64'({1'b1, 1'b0, 1'b0, 4'd0, 6'd20, 8'd33}));
    end
    @(posedge clk); #1 peak_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("scan_resume", 64'({peak_valid, rEnable, raddr}), 64'({1'b0, 1'b1, 4'd1, 6'd0}));
    @(posedge clk); #1;
    wait_done("stall");

    // reset in the middle of pixel 1, then rescan
    ram_clear();
    ram_wr(0, 10, 50);
    ram_wr(1, 45, 3);
    exp_clear();
    exp_bin[0] = 10; exp_cnt[0] = 50;
    exp_bin[1] = 45; exp_cnt[1] = 3;
    push_all();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rEnable && raddr == {4'd1, 6'd30}) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("reach_bin30");
    #1 res = 1'b0;
    #1 check("reset_midscan_outputs", all_outputs(), 64'(0));
    check("pixel0_before_reset", 64'(exp_q.size()), 64'(PIXELS - 1));
    exp_q.delete();
    @(negedge clk);
    check("reset_held_outputs", all_outputs(), 64'(0));
    @(posedge clk); #1 res = 1'b1;
    @(posedge clk); #1;
    exp_clear();
`ifdef SIFH_CLEAR_ON_READ_EN
    exp_bin[0] = 0;  exp_cnt[0] = 0;
`else
    exp_bin[0] = 10; exp_cnt[0] = 50;
`endif
    exp_bin[1] = 45; exp_cnt[1] = 3;
    push_all();
    pulse_start();
    wait_done("rescan");

    check("write_port", 64'(bad_wr), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
